// File: rtl/RV_pkg.sv
// Shared register-write payload types and writeback arbiter defaults.
package RV_pkg;

  localparam int unsigned XLEN       = 32;
  localparam int unsigned REG_ADDR_W = 5;

  localparam int unsigned WB_FIFO_DEPTH_DEFAULT   = 4;
  localparam int unsigned WB_STARVE_LIMIT_DEFAULT = 8;

  typedef logic [XLEN-1:0] OperandType;

  typedef struct packed {
    logic                  RegEnable;
    logic [REG_ADDR_W-1:0] RegAddr;
  } RegCtrlPortType;

  typedef struct packed {
    RegCtrlPortType WriteCtrl;
    OperandType     Data;
  } RegWritePortType;

endpackage

// File: rtl/rv_wb_fifo.sv
// Memory-result queue for the writeback arbiter: synchronous push/pop, registered count.
module rv_wb_fifo
  import RV_pkg::*;
#(
  parameter int unsigned DEPTH = WB_FIFO_DEPTH_DEFAULT
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         push,
  input  RegWritePortType              din,
  input  logic                         pop,
  output RegWritePortType              head_c,
  output logic [$clog2(DEPTH+1)-1:0]   count,
  output logic                         full_c,
  output logic                         empty_c
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  RegWritePortType   mem [DEPTH];
  logic [PTR_W-1:0]  wr_ptr;
  logic [PTR_W-1:0]  rd_ptr;
  logic              push_ok;
  logic              pop_ok;

  assign full_c  = (count == CNT_W'(DEPTH));
  assign empty_c = (count == '0);
  assign push_ok = push && !full_c;
  assign pop_ok  = pop && !empty_c;
  assign head_c  = mem[rd_ptr];

  // Storage carries no reset; count and pointers define which entries are live.
  always_ff @(posedge clk) begin
    if (push_ok) begin
      mem[wr_ptr] <= din;
    end
  end

  // Pointers wrap naturally since DEPTH is a power of two.
  always_ff @(posedge clk) begin
    if (rst) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop_ok)  rd_ptr <= rd_ptr + PTR_W'(1);
      unique case ({push_ok, pop_ok})
        2'b10:   count <= count + CNT_W'(1);
        2'b01:   count <= count - CNT_W'(1);
        default: count <= count;
      endcase
    end
  end

endmodule

// File: rtl/rv_wb_arbiter.sv
// Writeback arbiter: ALU results win, queued memory results fill idle slots.
// Optional starvation guard enabled by defining RV_WB_STARVE_GUARD_EN.
module rv_wb_arbiter
  import RV_pkg::*;
#(
  parameter int unsigned FIFO_DEPTH   = WB_FIFO_DEPTH_DEFAULT,
  parameter int unsigned STARVE_LIMIT = WB_STARVE_LIMIT_DEFAULT
) (
  input  logic            clk,
  input  logic            rst,
  input  RegWritePortType AluResult,
  input  logic            MemResultValid,
  input  RegWritePortType MemResult,
  output logic            MemResultReady,
  output RegWritePortType ExecResultBypass,
  output logic            AluStall,
  output logic            WbBusy
);

  localparam int unsigned CNT_W = $clog2(FIFO_DEPTH + 1);

  RegWritePortType   head_c;
  RegWritePortType   sel_c;
  logic [CNT_W-1:0]  count;
  logic              full_c;
  logic              empty_c;
  logic              alu_sel_c;
  logic              pop_c;
  logic              push_c;

  assign alu_sel_c      = AluResult.WriteCtrl.RegEnable;
  assign pop_c          = !alu_sel_c && !empty_c;
  assign MemResultReady = !rst && !full_c;
  assign push_c         = MemResultValid && MemResultReady;
  assign WbBusy         = (count != '0);

  rv_wb_fifo #(
    .DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .clk     (clk),
    .rst     (rst),
    .push    (push_c),
    .din     (MemResult),
    .pop     (pop_c),
    .head_c  (head_c),
    .count   (count),
    .full_c  (full_c),
    .empty_c (empty_c)
  );

  // Select winner; x0 writes are consumed but never enable the register file.
  always_comb begin
    sel_c = '0;
    if (alu_sel_c) begin
      sel_c = AluResult;
    end else if (pop_c) begin
      sel_c = head_c;
    end
    if (sel_c.WriteCtrl.RegAddr == '0) begin
      sel_c.WriteCtrl.RegEnable = 1'b0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      ExecResultBypass <= '0;
    end else begin
      ExecResultBypass <= sel_c;
    end
  end

`ifdef RV_WB_STARVE_GUARD_EN
  localparam int unsigned SW = $clog2(STARVE_LIMIT + 1);

  logic [SW-1:0] starve_q;
  logic [SW-1:0] starve_c;

  // Count cycles the queue head loses to the ALU; saturate at the limit.
  always_comb begin
    starve_c = starve_q;
    if (empty_c || pop_c) begin
      starve_c = '0;
    end else if (alu_sel_c && (starve_q != SW'(STARVE_LIMIT))) begin
      starve_c = starve_q + SW'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      starve_q <= '0;
      AluStall <= 1'b0;
    end else begin
      starve_q <= starve_c;
      AluStall <= (starve_c == SW'(STARVE_LIMIT));
    end
  end
`else
  assign AluStall = 1'b0;
`endif

endmodule

// File: tb/tb_rv_wb_arbiter.sv
// Self-checking bench for rv_wb_arbiter: queue-based reference model plus directed scenarios.
module tb_rv_wb_arbiter;
  import RV_pkg::*;

  localparam int unsigned DEPTH = 4;
  localparam int unsigned LIMIT = 8;
`ifdef RV_WB_STARVE_GUARD_EN
  localparam bit GUARD = 1'b1;
`else
  localparam bit GUARD = 1'b0;
`endif

  logic            clk = 1'b0;
  logic            rst;
  RegWritePortType alu;
  logic            mvalid;
  RegWritePortType mres;
  logic            mready;
  RegWritePortType bypass;
  logic            stall;
  logic            busy;

  int total = 0;
  int bad   = 0;

  always #5 clk = ~clk;

  rv_wb_arbiter #(
    .FIFO_DEPTH   (DEPTH),
    .STARVE_LIMIT (LIMIT)
  ) dut (
    .clk              (clk),
    .rst              (rst),
    .AluResult        (alu),
    .MemResultValid   (mvalid),
    .MemResult        (mres),
    .MemResultReady   (mready),
    .ExecResultBypass (bypass),
    .AluStall         (stall),
    .WbBusy           (busy)
  );

  function automatic RegWritePortType wr(input logic en, input logic [4:0] a, input logic [31:0] d);
    RegWritePortType r;
    r.WriteCtrl.RegEnable = en;
    r.WriteCtrl.RegAddr   = a;
    r.Data                = d;
    return r;
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  // Reference model: a plain queue of pending memory results and a losing-cycle tally.
  RegWritePortType mq[$];
  RegWritePortType exp_out;
  int              starve;
  bit              exp_stall;
  bit              model_ok = 1'b0;
  int              pre_size;
  bit              popped;

  always @(posedge clk) begin
    if (rst) begin
      mq.delete();
      exp_out   = '0;
      starve    = 0;
      exp_stall = 1'b0;
      model_ok  = 1'b1;
    end else begin
      pre_size = mq.size();
      popped   = 1'b0;
      exp_out  = '0;
      if (alu.WriteCtrl.RegEnable) begin
        exp_out = alu;
      end else if (pre_size > 0) begin
        exp_out = mq.pop_front();
        popped  = 1'b1;
      end
      if (exp_out.WriteCtrl.RegAddr == 5'd0) exp_out.WriteCtrl.RegEnable = 1'b0;
      if (mvalid && (pre_size < int'(DEPTH))) mq.push_back(mres);
      if (pre_size == 0 || popped) starve = 0;
      else if (starve < int'(LIMIT)) starve++;
      exp_stall = GUARD && (starve >= int'(LIMIT));
    end
  end

  always @(negedge clk) begin
    if (model_ok) begin
      check("cyc_bypass", 64'(bypass), 64'(exp_out));
      check("cyc_ready",  64'(mready), 64'(!rst && (mq.size() < int'(DEPTH))));
      check("cyc_busy",   64'(busy),   64'(mq.size() != 0));
      check("cyc_stall",  64'(stall),  64'(exp_stall));
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst = 1'b1; alu = '0; mvalid = 1'b0; mres = '0;
    tick(); tick();
    check("rst_bypass", 64'(bypass), 64'd0);
    check("rst_ready",  64'(mready), 64'd0);
    check("rst_busy",   64'(busy),   64'd0);
    rst = 1'b0;
    #1;
    check("ready_after_rst", 64'(mready), 64'd1);

    // Single memory result through an idle ALU: visible two edges after handshake
    mvalid = 1'b1; mres = wr(1'b1, 5'd5, 32'h1234);
    tick();
    mvalid = 1'b0; mres = '0;
    check("t31_not_yet", 64'(bypass), 64'd0);
    check("t31_busy", 64'(busy), 64'd1);
    tick();
    check("t31_out", 64'(bypass), 64'(wr(1'b1, 5'd5, 32'h1234)));
    check("t31_idle_busy", 64'(busy), 64'd0);
    tick();
    check("t31_single", 64'(bypass), 64'd0);

    // ALU wins over a queued entry, entry follows next cycle
    alu = wr(1'b1, 5'd1, 32'h11); mvalid = 1'b1; mres = wr(1'b1, 5'd7, 32'hBB);
    tick();
    mvalid = 1'b0; mres = '0;
    alu = wr(1'b1, 5'd3, 32'hAA);
    tick();
    check("t32_alu_first", 64'(bypass), 64'(wr(1'b1, 5'd3, 32'hAA)));
    alu = '0;
    tick();
    check("t32_mem_next", 64'(bypass), 64'(wr(1'b1, 5'd7, 32'hBB)));
    tick();

    // Fill the queue while the ALU is busy, hold a fifth, then drain in order
    for (int i = 0; i < 4; i++) begin
      alu = wr(1'b1, 5'(10 + i), 32'(i)); mvalid = 1'b1; mres = wr(1'b1, 5'(20 + i), 32'(32'h40 + i));
      tick();
    end
    check("t33_full_ready", 64'(mready), 64'd0);
    alu = wr(1'b1, 5'd14, 32'h5); mres = wr(1'b1, 5'd24, 32'h44);
    tick();
    check("t33_hold_ready", 64'(mready), 64'd0);
    check("t33_hold_busy", 64'(busy), 64'd1);
    tick();
    alu = '0;
    tick();
    check("t33_pop0", 64'(bypass), 64'(wr(1'b1, 5'd20, 32'h40)));
    check("t33_ready_back", 64'(mready), 64'd1);
    tick();
    mvalid = 1'b0; mres = '0;
    check("t33_pop1", 64'(bypass), 64'(wr(1'b1, 5'd21, 32'h41)));
    for (int k = 2; k < 5; k++) begin
      tick();
      check("t33_drain", 64'(bypass), 64'(wr(1'b1, 5'(20 + k), 32'(32'h40 + k))));
    end
    tick();
    check("t33_empty", 64'(busy), 64'd0);

    // Write to x0 is consumed with the enable masked
    alu = wr(1'b1, 5'd0, 32'hFFFF);
    tick();
    check("t34_x0", 64'(bypass), 64'(wr(1'b0, 5'd0, 32'hFFFF)));
    check("t34_busy", 64'(busy), 64'd0);
    alu = '0;
    tick();
    check("t34_after", 64'(bypass), 64'd0);

    // Starvation: one queued entry losing to a continuously valid ALU
    alu = wr(1'b1, 5'd2, 32'h2); mvalid = 1'b1; mres = wr(1'b1, 5'd9, 32'h99);
    tick();
    mvalid = 1'b0; mres = '0;
    for (int i = 1; i <= 8; i++) begin
      alu = wr(1'b1, 5'd2, 32'(32'h100 + i));
      tick();
      if (i == 7) check("t35_stall_pre", 64'(stall), 64'd0);
    end
    check("t35_stall", 64'(stall), 64'(GUARD));
    alu = wr(1'b1, 5'd6, 32'h666);
    tick();
    check("t35_alu_wins", 64'(bypass), 64'(wr(1'b1, 5'd6, 32'h666)));
    check("t35_stall_hold", 64'(stall), 64'(GUARD));
    alu = '0;
    tick();
    check("t35_pop", 64'(bypass), 64'(wr(1'b1, 5'd9, 32'h99)));
    check("t35_stall_clear", 64'(stall), 64'd0);
    tick();

    // Reset with queued entries discards them
    for (int i = 0; i < 3; i++) begin
      alu = wr(1'b1, 5'd1, 32'(i)); mvalid = 1'b1; mres = wr(1'b1, 5'(12 + i), 32'(32'h70 + i));
      tick();
    end
    check("t36_busy_pre", 64'(busy), 64'd1);
    rst = 1'b1; alu = wr(1'b1, 5'd4, 32'h55); mvalid = 1'b1;
    #1;
    check("t36_ready_in_rst", 64'(mready), 64'd0);
    tick();
    check("t36_bypass", 64'(bypass), 64'd0);
    check("t36_busy", 64'(busy), 64'd0);
    check("t36_stall", 64'(stall), 64'd0);
    rst = 1'b0; alu = '0; mvalid = 1'b0; mres = '0;
    #1;
    check("t36_ready_after", 64'(mready), 64'd1);
    tick();
    check("t36_no_write", 64'(bypass), 64'd0);
    tick();
    check("t36_no_write2", 64'(bypass), 64'd0);
    check("t36_busy_after", 64'(busy), 64'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

// File: doc/rv_wb_arbiter.md
RV_WB_ARBITER -- requirements
Module: rv_wb_arbiter

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, memory-result queue entries (power of 2, >=2).
REQ-002 SHALL have parameter STARVE_LIMIT, default 8, consecutive cycles a queued memory result may lose arbitration before AluStall asserts.
REQ-003 SHALL have port clk  in  1  sole clock, all state on rising edge.
REQ-004 SHALL have port rst  in  1  reset, synchronous and active-high.
REQ-005 SHALL have port AluResult  in  RegWritePortType  single-cycle ALU result, valid when WriteCtrl.RegEnable=1.
REQ-006 SHALL have port MemResultValid  in  1  long-latency (load/mul/div) result valid.
REQ-007 SHALL have port MemResult  in  RegWritePortType  long-latency result payload.
REQ-008 SHALL have port MemResultReady  out  1  queue can accept a memory result.
REQ-009 SHALL have port ExecResultBypass  out  RegWritePortType  registered write/bypass port driving the register file.
REQ-010 SHALL have port AluStall  out  1  request to upstream to withhold ALU results.
REQ-011 SHALL have port WbBusy  out  1  queue non-empty.

Function
REQ-012 ALU result SHALL always be accepted, with no backpressure.
REQ-013 Memory handshake SHALL complete when MemResultValid&&MemResultReady; payload pushed to queue tail.
REQ-014 MemResultReady SHALL be !full from registered count only, with no combinational path from MemResultValid or AluResult.
REQ-015 Arbitration per cycle: ALU valid -> select ALU; else queue non-empty -> select and pop head; else idle.
REQ-016 Selected result SHALL appear on ExecResultBypass on the next rising edge (latency 1); minimum memory path latency 2 (push, then pop).
REQ-017 Idle cycle SHALL drive ExecResultBypass all-zero (RegEnable=0, RegAddr=0, data=0).
REQ-018 Selected result with RegAddr=0 SHALL be output with RegEnable forced 0; the entry still counts as consumed.
REQ-019 Push and pop in the same cycle SHALL leave count unchanged; when full, no push occurs even if a pop occurs that cycle.
REQ-020 Pointers SHALL wrap modulo FIFO_DEPTH; queue order SHALL be strict FIFO.
REQ-021 No WAW check: the upstream scoreboard guarantees no two in-flight writes target the same register.
REQ-022 WbBusy SHALL equal (count!=0), registered.

Reset
REQ-023 While rst=1 on a clock edge: count, pointers, starve counter cleared; ExecResultBypass all-zero; AluStall=0.
REQ-024 MemResultReady SHALL be 0 while rst=1 and 1 from the first cycle after rst deasserts.
REQ-025 Reset mid-operation SHALL discard all queued results with no write issued.

Configuration
REQ-026 Macro RV_WB_STARVE_GUARD_EN defined: starve counter increments each cycle queue non-empty and ALU selected; clears on pop or when empty; AluStall registered high when counter reaches STARVE_LIMIT.
REQ-027 With guard: AluStall SHALL deassert the cycle after the next pop; an ALU result presented during AluStall SHALL still win and is never dropped.
REQ-028 Macro undefined: AluStall tied 0, no counter logic present.

Structure
REQ-029 RegWritePortType, RegCtrlPortType, OperandType SHALL come from RV_pkg; default depth/limit constants SHALL be added to RV_pkg.
REQ-030 Queue SHALL be sub-module rv_wb_fifo (sync push/pop, count, full/empty); arbitration, x0 masking and starve guard stay in rv_wb_arbiter.

Verification
REQ-031 Idle ALU, one memory push (addr 5, data 0x1234) -> ExecResultBypass {1,5,0x1234} two cycles after handshake, single cycle.
REQ-032 ALU valid (addr 3, 0xAA) same cycle as queued memory entry (addr 7, 0xBB) -> addr 3 output first, addr 7 the following cycle.
REQ-033 Push 4 with ALU busy -> MemResultReady=0 after 4th; fifth valid held; one ALU-idle cycle -> pop, ready=1 next cycle, order preserved.
REQ-034 ALU write to addr 0 data 0xFFFF -> output RegEnable=0, no other effect.
REQ-035 Guard enabled: 1 queued entry, ALU valid continuously -> AluStall=1 after 8 losing cycles; drop ALU valid -> pop, AluStall=0 next cycle.
REQ-036 rst=1 with 3 queued entries -> no writes issued, WbBusy=0, all outputs zero; MemResultReady=1 the first cycle after rst drops.
